lbist_scan_ctrl: RTL
====================

// Module: lbist_scan_ctrl
// PURPOSE
//  Logic-BIST wrapper controller for the s9234 scan core. An LFSR generates scan-in bits and
//  primary-input (PI) values. The controller sequences shift/capture/shift and compacts the
//  unloaded chain data and captured primary outputs (PO) into a MISR signature.
//  It sits between the test access port and the DUT: it drives scan_en, scan_in and PIs, and
//  consumes scan_out and POs.
// PARAMETERS
//  CHAIN_LEN  228  scan flops in the DUT chain (>=2)
//  PI_W       36   DUT primary inputs
//  PO_W       39   DUT primary outputs (<=64)
// PORTS
//  CK         in   1      clock, rising edge; shared with DUT
//  RST        in   1      asynchronous, active-high reset
//  start      in   1      begin a BIST run; sampled in IDLE only
//  num_pat    in   16     number of patterns to apply
//  seed       in   32     LFSR seed, loaded on start
//  busy       out  1      high from cycle after start until done
//  done       out  1      one-cycle pulse at end of run
//  signature  out  32     MISR value; held after done until next start
//  scan_en    out  1      1 = shift, 0 = capture
//  scan_in    out  1      serial data into chain head
//  scan_out   in   1      serial data from chain tail
//  pi         out  PI_W   DUT primary inputs
//  po         in   PO_W   DUT primary outputs
// BEHAVIOUR
//  Reset: all regs/outputs 0. FSM enters IDLE. Any state aborts immediately, with no done pulse.
//  FSM: IDLE -> SHIFT -> CAPTURE -> SHIFT ... -> FLUSH -> DONE -> IDLE.
//  IDLE on start=1:
//   - lfsr<=(seed==0)?1:seed; misr<=0; pat_cnt<=0; sh_cnt<=0.
//   - Next state SHIFT if num_pat!=0, else DONE.
//  SHIFT: scan_en=1 for exactly CHAIN_LEN cycles.
//   - Each cycle: lfsr<={lfsr[30:0],lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
//   - scan_in=lfsr[31] (registered, aligned with scan_en).
//   - pi<={pi[PI_W-2:0],lfsr[31]}.
//   - After the last shift cycle: pat_cnt<pat count -> CAPTURE.
//  CAPTURE: 1 cycle, scan_en=0; pi, scan_in and lfsr held.
//   - misr <= step(misr, fold(po)), where fold(po) = po[31:0] ^ (po>>32), zero-extended.
//   - pat_cnt++. Next: SHIFT if pat_cnt+1<num_pat, else FLUSH.
//  FLUSH: CHAIN_LEN shift cycles. scan_en=1, scan_in=0, lfsr and pi held. Then DONE.
//  DONE: done=1 for one cycle, busy=0, signature valid. Next IDLE.
//  MISR step(m,d): m'={m[30:0],1'b0} ^ (m[31]?32'h0040_0007:0) ^ d.
//  Unload compaction:
//   - In SHIFT cycles of patterns 2..N and in FLUSH cycles: misr<=step(misr,{31'b0,scan_out}).
//   - First-pattern SHIFT ignores scan_out (chain contents unknown).
//   - CAPTURE uses fold(po) only.
//  Run length: N*(CHAIN_LEN+1)+CHAIN_LEN busy cycles. done follows the last FLUSH cycle.
//  Edge cases:
//   - start while busy: ignored.
//   - num_pat change mid-run: no effect (num_pat latched at start).
//   - X on scan_out: not masked; verification treats X propagation into misr as failure.
//   - sh_cnt wraps to 0 at CHAIN_LEN-1; pat_cnt does not wrap (num_pat<=65535).
//  signature = misr register, continuously driven. Stable only in DONE/IDLE.
// TESTING
//  1. RST held, then released:
//     -> scan_en=0, scan_in=0, pi=0, busy=0, done=0, signature=0.
//  2. num_pat=0, start pulse:
//     -> busy never asserts; done=1 on the 2nd cycle after start; signature=0.
//  3. num_pat=1, seed=1, CHAIN_LEN=228, chain modelled as 228-bit shift reg, po=0:
//     -> scan_en low exactly 1 cycle at cycle 229.
//     -> done pulses after 457 busy cycles.
//     -> signature equals C golden model.
//  4. num_pat=3, seed=32'hDEADBEEF, po=random per capture:
//     -> 3 capture cycles spaced 229 apart.
//     -> signature matches golden model.
//     -> repeated run gives identical signature.
//  5. seed=0 vs seed=1, same num_pat=2:
//     -> identical scan_in stream and signature.
//  6. RST asserted mid-SHIFT of pattern 2:
//     -> outputs 0 in same cycle (async), no done.
//     -> new start reruns cleanly with the expected signature.
//     -> start pulsed while busy has no effect on cycle count.

Source files
------------

// File: rtl/lbist_scan_ctrl_if.sv
// Bundle of the test-access and scan-side signals around the LBIST controller.
// The master side starts runs and models the core; the slave side is the controller.
`timescale 1ns/1ps
interface lbist_scan_ctrl_if #(
    parameter int PI_W = 36,
    parameter int PO_W = 39
);
    logic            start;
    logic [15:0]     num_pat;
    logic [31:0]     seed;
    logic            busy;
    logic            done;
    logic [31:0]     signature;
    logic            scan_en;
    logic            scan_in;
    logic            scan_out;
    logic [PI_W-1:0] pi;
    logic [PO_W-1:0] po;

    modport master (
        output start, num_pat, seed, scan_out, po,
        input  busy, done, signature, scan_en, scan_in, pi
    );

    modport slave (
        input  start, num_pat, seed, scan_out, po,
        output busy, done, signature, scan_en, scan_in, pi
    );
endinterface

// File: rtl/lbist_scan_ctrl.sv
// Logic-BIST controller: LFSR-driven shift/capture sequencing of one scan chain,
// with scan-out and primary-output compaction into a 32-bit MISR signature.
`timescale 1ns/1ps
module lbist_scan_ctrl #(
    parameter int CHAIN_LEN = 228,
    parameter int PI_W      = 36,
    parameter int PO_W      = 39
) (
    input  logic             clk_i,
    input  logic             rst_i,
    lbist_scan_ctrl_if.slave bus
);

    localparam int              CntW     = $clog2(CHAIN_LEN);
    localparam logic [CntW-1:0] ShLast   = CntW'(CHAIN_LEN - 1);
    localparam logic [31:0]     MisrPoly = 32'h0040_0007;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

    state_t          state_q,   state_d;
    logic [31:0]     lfsr_q,    lfsr_d;
    logic [31:0]     misr_q,    misr_d;
    logic [15:0]     patCnt_q,  patCnt_d;
    logic [15:0]     numPat_q,  numPat_d;
    logic [CntW-1:0] shCnt_q,   shCnt_d;
    logic [PI_W-1:0] pi_q,      pi_d;
    logic            scanIn_q,  scanIn_d;
    logic            scanEn_q,  scanEn_d;
    logic            busy_q,    busy_d;
    logic            done_q,    done_d;

    logic [31:0]     lfsrNext;
    logic [63:0]     poWide;
    logic [31:0]     poFold;
    logic [16:0]     patNext;

    function automatic logic [31:0] misrStep(input logic [31:0] m, input logic [31:0] d);
        return {m[30:0], 1'b0} ^ (m[31] ? MisrPoly : 32'h0) ^ d;
    endfunction

    assign lfsrNext = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    assign poWide   = 64'(bus.po);
    assign poFold   = poWide[31:0] ^ poWide[63:32];
    assign patNext  = {1'b0, patCnt_q} + 17'd1;

    // Outputs are registered from the next-state decode so they line up with the state.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        misr_d   = misr_q;
        patCnt_d = patCnt_q;
        numPat_d = numPat_q;
        shCnt_d  = shCnt_q;
        pi_d     = pi_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    lfsr_d   = (bus.seed == 32'h0) ? 32'h1 : bus.seed;
                    misr_d   = 32'h0;
                    patCnt_d = 16'h0;
                    shCnt_d  = '0;
                    numPat_d = bus.num_pat;
                    state_d  = (bus.num_pat != 16'h0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                lfsr_d = lfsrNext;
                pi_d   = {pi_q[PI_W-2:0], lfsr_q[31]};
                // The first pattern unloads the chain's unknown power-up contents.
                if (patCnt_q != 16'h0) begin
                    misr_d = misrStep(misr_q, {31'b0, bus.scan_out});
                end
                if (shCnt_q == ShLast) begin
                    shCnt_d = '0;
                    state_d = CAPTURE;
                end else begin
                    shCnt_d = shCnt_q + 1'b1;
                end
            end
            CAPTURE: begin
                misr_d   = misrStep(misr_q, poFold);
                patCnt_d = patNext[15:0];
                state_d  = (patNext < {1'b0, numPat_q}) ? SHIFT : FLUSH;
            end
            FLUSH: begin
                misr_d = misrStep(misr_q, {31'b0, bus.scan_out});
                if (shCnt_q == ShLast) begin
                    shCnt_d = '0;
                    state_d = DONE;
                end else begin
                    shCnt_d = shCnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        scanEn_d = (state_d == SHIFT) || (state_d == FLUSH);
        busy_d   = (state_d == SHIFT) || (state_d == CAPTURE) || (state_d == FLUSH);
        done_d   = (state_d == DONE);

        if (state_d == SHIFT) begin
            scanIn_d = lfsr_d[31];
        end else if (state_d == CAPTURE) begin
            scanIn_d = scanIn_q;
        end else begin
            scanIn_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            lfsr_q   <= 32'h0;
            misr_q   <= 32'h0;
            patCnt_q <= 16'h0;
            numPat_q <= 16'h0;
            shCnt_q  <= '0;
            pi_q     <= '0;
            scanIn_q <= 1'b0;
            scanEn_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            misr_q   <= misr_d;
            patCnt_q <= patCnt_d;
            numPat_q <= numPat_d;
            shCnt_q  <= shCnt_d;
            pi_q     <= pi_d;
            scanIn_q <= scanIn_d;
            scanEn_q <= scanEn_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.signature = misr_q;
    assign bus.scan_en   = scanEn_q;
    assign bus.scan_in   = scanIn_q;
    assign bus.pi        = pi_q;

endmodule
